// File: rtl/fp32_byte_tx_if.sv
// fp32_byte_tx_if: word-in / byte-out stream bundle for fp32_byte_tx.
// master = upstream/host side, slave = the serialiser itself.
interface fp32_byte_tx_if #(
    parameter int DEPTH = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_byte;
    logic                     out_last;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     idle;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_byte, out_last, fifo_count, idle
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_byte, out_last, fifo_count, idle
    );
endinterface

// File: rtl/fp32_byte_tx.sv
// fp32_byte_tx: buffers fp32 words in a FIFO and emits each as four bytes with a per-word last marker.
// Optional per-vector 0xA5 sync header when FP32_TX_HEADER_EN is defined.
module fp32_byte_tx #(
    parameter int DEPTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    fp32_byte_tx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

`ifdef FP32_TX_HEADER_EN
    typedef enum logic [1:0] {IDLE, HEADER, SEND} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    logic [32:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    logic [32:0]   r_hold;
    logic [1:0]    r_idx;
    logic          r_out_valid;
    logic          r_out_last;
    logic [7:0]    r_out_byte;
    logic          r_idle;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_last_taken;
    logic          w_next_idle;
    logic [32:0]   w_rd_word;
    logic [AW:0]   w_count_next;
    logic [1:0]    w_idx_inc;
    logic [7:0]    w_rd_bytes   [4];
    logic [7:0]    w_hold_bytes [4];

    assign w_full       = (r_count == (AW+1)'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push       = bus.in_valid & bus.in_ready;
    assign w_last_taken = (r_state == SEND) & bus.out_ready & (r_idx == 2'd3);
    // Reload straight from the FIFO on the 4th byte so back-to-back words have no bubble.
    assign w_pop        = ~w_empty & ((r_state == IDLE) | w_last_taken);
    assign w_next_idle  = ~w_pop & ((r_state == IDLE) | w_last_taken);
    assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    assign w_rd_word    = r_mem[r_rd_ptr];
    assign w_idx_inc    = r_idx + 2'd1;

    // Byte lanes in transmit order: lane 0 is sent first.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam int LO = MSB_FIRST ? 8 * (3 - gi) : 8 * gi;
            assign w_rd_bytes[gi]   = w_rd_word[LO +: 8];
            assign w_hold_bytes[gi] = r_hold[LO +: 8];
        end
    endgenerate

`ifdef FP32_TX_HEADER_EN
    logic r_need_hdr;
    logic w_hdr_due;
    // A reload inside SEND starts a new vector exactly when the word just finished carried last.
    assign w_hdr_due = (r_state == SEND) ? r_hold[32] : r_need_hdr;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_last, bus.in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= IDLE;
            r_hold      <= '0;
            r_idx       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_byte  <= 8'h00;
            r_idle      <= 1'b1;
`ifdef FP32_TX_HEADER_EN
            r_need_hdr  <= 1'b1;
`endif
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_idle  <= (w_count_next == '0) & w_next_idle;

            if (w_pop) begin
                r_hold      <= w_rd_word;
                r_idx       <= 2'd0;
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b0;
`ifdef FP32_TX_HEADER_EN
                if (w_hdr_due) begin
                    r_state    <= HEADER;
                    r_out_byte <= 8'hA5;
                    r_need_hdr <= 1'b0;
                end else begin
                    r_state    <= SEND;
                    r_out_byte <= w_rd_bytes[0];
                end
`else
                r_state    <= SEND;
                r_out_byte <= w_rd_bytes[0];
`endif
            end else begin
                case (r_state)
                    SEND: begin
                        if (bus.out_ready) begin
                            if (r_idx != 2'd3) begin
                                r_idx      <= w_idx_inc;
                                r_out_byte <= w_hold_bytes[w_idx_inc];
                                r_out_last <= r_hold[32] & (w_idx_inc == 2'd3);
                            end else begin
                                r_state     <= IDLE;
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
`ifdef FP32_TX_HEADER_EN
                                r_need_hdr  <= r_hold[32];
`endif
                            end
                        end
                    end
`ifdef FP32_TX_HEADER_EN
                    HEADER: begin
                        if (bus.out_ready) begin
                            r_state    <= SEND;
                            r_out_byte <= w_hold_bytes[0];
                            r_out_last <= 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready   = ~rst & ~w_full;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_byte   = r_out_byte;
    assign bus.out_last   = r_out_last;
    assign bus.fifo_count = r_count;
    assign bus.idle       = r_idle;
endmodule

// File: doc/fp32_byte_tx.md
# fp32_byte_tx

Byte-serialising output stage for the fp32 words produced by the fixed-point-to-float converter. It buffers incoming 32-bit words in a small FIFO and emits each word as four bytes over a valid/ready byte stream for the host link (UART/DMA byte port). It carries a per-word end-of-vector marker through to the last byte of that word. It sits directly downstream of the fxp-to-fp32 conversion of the decoder output.

## Interface
- `DEPTH`, 8: FIFO depth in words. Must be a power of two, ≥ 2.
- `MSB_FIRST`, 1: 1 sends byte [31:24] first; 0 sends byte [7:0] first.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data`/`in_last` valid.
- `in_ready`  out  1  FIFO can accept a word; equals `~rst & ~full`.
- `in_data`  in  32  fp32 word (sign, exp[7:0], mantissa[22:0]).
- `in_last`  in  1  word is the final element of a vector.
- `out_valid`  out  1  `out_byte` valid.
- `out_ready`  in  1  downstream accepts the byte.
- `out_byte`  out  8  current byte.
- `out_last`  out  1  high on the final byte of a word tagged `in_last`.
- `fifo_count`  out  $clog2(DEPTH)+1  words held in the FIFO, excluding the word being sent.
- `idle`  out  1  FIFO empty and FSM in IDLE.

## Operation
- FIFO entries are 33 bits, {last, data}. A push occurs on `in_valid & in_ready`. A pop occurs only when the FSM loads a word.
- A push and a pop in the same cycle are both allowed. `fifo_count` is then unchanged. Pointers wrap modulo DEPTH.
- When full, `in_ready` is 0 and the push is refused, even if a pop occurs that cycle.
- A word popped from the FIFO is copied into a holding register `hold[32:0]` with byte index `idx[1:0]`.
- FSM states:
  - IDLE: `out_valid`=0. If the FIFO is non-empty, pop into `hold`, set `idx`=0, and go to SEND.
  - SEND: `out_valid`=1. `out_byte` = `hold` byte `idx` in the order set by MSB_FIRST.
    - On `out_ready`, if `idx`<3, increment `idx`.
    - On `out_ready` with `idx`==3: if the FIFO is non-empty, pop the next word into `hold`, set `idx`=0, and stay in SEND (no bubble). Otherwise go to IDLE.
- `out_last` = `hold[32] & (idx==3)` while in SEND, else 0.
- While `out_valid`=1 and `out_ready`=0, `out_byte` and `out_last` hold stable.
- Data are passed bit-exact. There is no interpretation of the fp32 fields; zero, negative values and specials are passed unchanged.

## Timing
- Reset values: `out_valid`=0, `out_byte`=0x00, `out_last`=0, `fifo_count`=0, `idle`=1, `in_ready`=0 while `rst` is high. Pointers, `idx` and `hold` are cleared and the FSM is in IDLE.
- Reset asserted mid-word clears everything immediately. Partially sent and buffered words are discarded. `in_ready` rises in the first cycle `rst` is low.
- Latency: with the block idle, a word pushed at edge N is loaded at edge N+1, and `out_valid` is high in the cycle after N+1.
- Sustained throughput is 1 byte/cycle with `out_ready`=1, i.e. 1 word per 4 cycles.
- Upstream therefore sees back-pressure after DEPTH words if it pushes faster than 1 word per 4 cycles.
- `fifo_count` and `idle` are registered and reflect state after the current edge.

## Configuration
- `FP32_TX_HEADER_EN`:
  - Defined: adds a HEADER state. Before the first word of each vector (after reset, or after a byte sent with `out_last`=1), the FSM emits sync byte 0xA5 with `out_last`=0, then proceeds to the word's 4 bytes.
    - Sequence: IDLE→HEADER (word loaded into `hold`)→SEND.
    - The header byte obeys the same valid/ready hold rules.
  - Not defined: no HEADER state; behaviour is exactly as in Operation.

## Test plan
- Reset then push 0x3F7E0000 (last=1), MSB_FIRST=1, `out_ready`=1 → `out_byte` 0x3F, 0x7E, 0x00, 0x00 on consecutive cycles, `out_last` only on the 4th byte, first byte 2 cycles after the push; `idle` returns to 1.
- MSB_FIRST=0, push 0xBF800000 → bytes 0x00, 0x00, 0x80, 0xBF.
- `out_ready`=0, push 9 words with DEPTH=8 → `in_ready` drops after the 9th push is loaded; `fifo_count` reaches 8; releasing `out_ready` yields all 36 bytes in order with no gap between words.
- Random `out_ready` stalls over 100 random words → byte stream matches the scoreboard, and `out_byte` is stable during every stall.
- Reset asserted while byte 2 of a word is pending with 3 words queued → next cycle `out_valid`=0, `fifo_count`=0; a subsequent push of 0x00000000 emits four 0x00 bytes.
- With `FP32_TX_HEADER_EN`, push words A, B (last=1), C → 0xA5, A[4], B[4] with `out_last` on B's 4th byte, then 0xA5, C[4].
